// File: rtl/midi_pkg.sv
// Shared types and helpers for the MIDI message parser: FSM states, status
// constants, per-status data length and the internal output-event record.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_e;

  localparam logic [7:0] ST_SYSEX  = 8'hF0;
  localparam logic [7:0] ST_EOX    = 8'hF7;
  localparam logic [7:0] ST_RT_MIN = 8'hF8;

  // One pending output: either an error pulse or a framed message.
  typedef struct packed {
    logic       is_err;
    logic [7:0] status;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [1:0] len;
  } evt_t;

  function automatic logic [1:0] data_len(input logic [7:0] st);
    logic [1:0] len;
    len = 2'd0;
    case (st[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF:
        case (st[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      default: len = 2'd0;
    endcase
    return len;
  endfunction

  function automatic logic is_channel_msg(input logic [7:0] st);
    return st[7] && (st[7:4] != 4'hF);
  endfunction

  // Undefined system statuses, and EOX seen outside a SysEx dump.
  function automatic logic is_bad_status(input logic [7:0] st);
    return (st == 8'hF4) || (st == 8'hF5) || (st == ST_EOX);
  endfunction

  function automatic evt_t mk_msg(input logic [7:0] st, input logic [6:0] d1,
                                  input logic [6:0] d2, input logic [1:0] len);
    evt_t e;
    e.is_err = 1'b0;
    e.status = st;
    e.d1     = d1;
    e.d2     = d2;
    e.len    = len;
    return e;
  endfunction

endpackage

// File: rtl/midi_timeout_ctr.sv
// Inter-byte timeout counter: restarts on reload, counts while enabled, and
// flags expiry after TIMEOUT_CYC quiet cycles (TIMEOUT_CYC = 0 disables it).
module midi_timeout_ctr #(
  parameter int          CNT_W       = 24,
  parameter logic [31:0] TIMEOUT_CYC = 32'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload_i,
  input  logic en_i,
  output logic expire_o
);

  localparam bit               TO_EN = (TIMEOUT_CYC != 32'd0);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 32'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i || !en_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = TO_EN && en_i && !reload_i && (cnt_q == LIMIT);

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: frames messages with running status, SysEx skip,
// channel filter and inter-byte timeout. Optional macro: MIDI_REALTIME_PASS_EN.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter logic [15:0] CH_MASK     = 16'hFFFF,
  parameter logic [31:0] TIMEOUT_CYC = 32'd0,
  parameter int          CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       msg_vld,
  output logic [7:0] msg_status,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2,
  output logic [1:0] msg_len,
  output logic       err,
  output logic       rt_vld,
  output logic [7:0] rt_byte
);

  state_e     state_q, state_d;
  logic [7:0] st_q, st_d;
  logic       rs_vld_q, rs_vld_d;
  logic [6:0] d1_q, d1_d;
  evt_t       pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;

  logic       msg_vld_q, err_q;
  logic [7:0] msg_status_q;
  logic [6:0] msg_d1_q, msg_d2_q;
  logic [1:0] msg_len_q;

  logic       is_rt, byte_vld, expire, in_wait;
  logic [1:0] len_st;
  logic       pass_st;
  logic       ev_err, ev_msg;
  evt_t       msg_ev, err_ev, out_ev;
  logic       out_v;

  assign is_rt    = din_vld && (din >= ST_RT_MIN);
  assign byte_vld = din_vld && !is_rt;
  assign in_wait  = (state_q == WAIT_D1) || (state_q == WAIT_D2);
  assign len_st   = data_len(st_q);
  assign pass_st  = !is_channel_msg(st_q) || CH_MASK[st_q[3:0]];

  midi_timeout_ctr #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .reload_i(byte_vld),
    .en_i    (in_wait),
    .expire_o(expire)
  );

  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    rs_vld_d = rs_vld_q;
    d1_d     = d1_q;
    ev_err   = 1'b0;
    ev_msg   = 1'b0;
    msg_ev   = '0;
    if (byte_vld) begin
      if (din[7]) begin
        if ((state_q == SYSEX) && (din == ST_EOX)) begin
          state_d = IDLE;
        end else begin
          // A status byte always restarts framing; cutting into a partial message is an error.
          ev_err   = in_wait;
          state_d  = IDLE;
          rs_vld_d = 1'b0;
          if (din == ST_SYSEX) begin
            state_d = SYSEX;
          end else if (is_bad_status(din)) begin
            ev_err = 1'b1;
          end else if (data_len(din) == 2'd0) begin
            ev_msg = 1'b1;
            msg_ev = mk_msg(din, 7'd0, 7'd0, 2'd0);
          end else begin
            st_d     = din;
            rs_vld_d = is_channel_msg(din);
            state_d  = WAIT_D1;
          end
        end
      end else if ((state_q == IDLE) && !rs_vld_q) begin
        ev_err = 1'b1;
      end else if ((state_q == IDLE) || (state_q == WAIT_D1)) begin
        if (len_st == 2'd1) begin
          ev_msg  = pass_st;
          msg_ev  = mk_msg(st_q, din[6:0], 7'd0, 2'd1);
          state_d = IDLE;
        end else begin
          d1_d    = din[6:0];
          state_d = WAIT_D2;
        end
      end else if (state_q == WAIT_D2) begin
        ev_msg  = pass_st;
        msg_ev  = mk_msg(st_q, d1_q, din[6:0], 2'd2);
        state_d = IDLE;
      end
    end else if (expire) begin
      ev_err   = 1'b1;
      state_d  = IDLE;
      rs_vld_d = 1'b0;
    end
  end

  // err and msg_vld share one output slot; a len-0 cut-in yields both, so the message waits a cycle.
  always_comb begin
    err_ev        = '0;
    err_ev.is_err = 1'b1;
    out_ev        = '0;
    out_v         = 1'b0;
    pend_d        = pend_q;
    pend_vld_d    = 1'b0;
    if (pend_vld_q) begin
      out_v  = 1'b1;
      out_ev = pend_q;
      if (ev_err) begin
        pend_d     = err_ev;
        pend_vld_d = 1'b1;
      end else if (ev_msg) begin
        pend_d     = msg_ev;
        pend_vld_d = 1'b1;
      end
    end else if (ev_err) begin
      out_v  = 1'b1;
      out_ev = err_ev;
      if (ev_msg) begin
        pend_d     = msg_ev;
        pend_vld_d = 1'b1;
      end
    end else if (ev_msg) begin
      out_v  = 1'b1;
      out_ev = msg_ev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      st_q         <= 8'd0;
      rs_vld_q     <= 1'b0;
      d1_q         <= 7'd0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      msg_vld_q    <= 1'b0;
      err_q        <= 1'b0;
      msg_status_q <= 8'd0;
      msg_d1_q     <= 7'd0;
      msg_d2_q     <= 7'd0;
      msg_len_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      rs_vld_q   <= rs_vld_d;
      d1_q       <= d1_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      msg_vld_q  <= out_v && !out_ev.is_err;
      err_q      <= out_v && out_ev.is_err;
      if (out_v && !out_ev.is_err) begin
        msg_status_q <= out_ev.status;
        msg_d1_q     <= out_ev.d1;
        msg_d2_q     <= out_ev.d2;
        msg_len_q    <= out_ev.len;
      end
    end
  end

  assign msg_vld    = msg_vld_q;
  assign err        = err_q;
  assign msg_status = msg_status_q;
  assign msg_d1     = msg_d1_q;
  assign msg_d2     = msg_d2_q;
  assign msg_len    = msg_len_q;

`ifdef MIDI_REALTIME_PASS_EN
  logic       rt_vld_q;
  logic [7:0] rt_byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_vld_q  <= 1'b0;
      rt_byte_q <= 8'd0;
    end else begin
      rt_vld_q <= is_rt;
      if (is_rt) begin
        rt_byte_q <= din;
      end
    end
  end

  assign rt_vld  = rt_vld_q;
  assign rt_byte = rt_byte_q;
`else
  assign rt_vld  = 1'b0;
  assign rt_byte = 8'd0;
`endif

endmodule
